tsn_strict_priority_scheduler: RTL and testbench
================================================

# tsn_strict_priority_scheduler

Packet-granular egress scheduler for the TSN switch datapath. Merges NUM_QUEUES AXI4-Stream traffic-class queues (output of classification/untagging, one stream per priority) onto one egress AXIS stream. Grant policy is strict priority, highest queue index wins. Grants are never preempted within a packet. An optional time-aware gate mask restricts which classes may start a packet.

## Interface
Parameters:
- C_DATA_WIDTH, 256, AXIS data width in bits
- C_TUSER_WIDTH, 128, AXIS tuser width in bits
- NUM_QUEUES, 4, number of traffic-class inputs (2..8); index NUM_QUEUES-1 = highest priority
- QW, $clog2(NUM_QUEUES), width of grant index (localparam)

Ports:
- clk  in  1  core clock (125 MHz)
- reset  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  NUM_QUEUES*C_DATA_WIDTH  queue q occupies slice q
- s_axis_tkeep  in  NUM_QUEUES*C_DATA_WIDTH/8  per-queue byte enables
- s_axis_tuser  in  NUM_QUEUES*C_TUSER_WIDTH  per-queue sideband
- s_axis_tvalid  in  NUM_QUEUES  per-queue valid
- s_axis_tlast  in  NUM_QUEUES  per-queue end of packet
- s_axis_tready  out  NUM_QUEUES  per-queue ready; at most one bit set
- m_axis_tdata  out  C_DATA_WIDTH  egress data
- m_axis_tkeep  out  C_DATA_WIDTH/8  egress byte enables
- m_axis_tuser  out  C_TUSER_WIDTH  egress sideband
- m_axis_tvalid  out  1  egress valid
- m_axis_tlast  out  1  egress end of packet
- m_axis_tready  in  1  egress ready
- gate_open  in  NUM_QUEUES  per-class transmission gate, 1 = open (present only with TSN_GATE_CTRL_EN)
- grant_q  out  QW  index of the queue currently granted
- busy  out  1  high while a packet is in transfer

## Operation
- Two-state FSM with registered state, grant_q and busy.
- IDLE:
  - eligible[q] = s_axis_tvalid[q] & gate_open[q].
  - If any queue is eligible, latch grant_q = highest eligible index, set busy, go to PASS.
  - Else stay in IDLE.
  - m_axis_tvalid = 0 and s_axis_tready = 0 throughout IDLE.
- PASS (combinational mux on registered grant_q):
  - m_axis_tdata/tkeep/tuser/tlast/tvalid = slice grant_q of the corresponding s_axis_* input.
  - s_axis_tready[grant_q] = m_axis_tready; all other tready bits = 0.
- PASS exit: on a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast, clear busy and go to IDLE.
- No preemption: if a higher-priority queue asserts valid mid-packet, it waits for the current tlast.
- If the granted queue deasserts tvalid mid-packet, hold the grant and emit bubbles (m_axis_tvalid = 0).
- tdata, tkeep and tuser pass unmodified, with no width change. No tkeep-based packet validation.

## Timing
- Reset values: state IDLE, grant_q 0, busy 0, m_axis_tvalid 0, s_axis_tready all 0, m_axis_tlast 0.
  - Asynchronous assertion mid-packet aborts the transfer immediately. The partial packet is the upstream/downstream's concern.
- Arbitration latency: request valid in cycle N (FSM in IDLE) → first beat may complete in cycle N+1.
- Inter-packet gap: exactly one idle cycle after each tlast handshake, used for re-arbitration. A one-beat packet occupies 2 cycles.
- Throughput: one beat per cycle inside a packet when source valid and sink ready.
- Simultaneous requests in the same IDLE cycle: highest index wins; lower ones are served in later IDLE cycles.
- tlast handshake and a new request in the same cycle: the new request is considered in the following IDLE cycle, never in the same cycle.
- AXIS rule: m_axis_tvalid never depends on m_axis_tready; outputs are held stable while valid & !ready.

## Configuration
- TSN_GATE_CTRL_EN defined:
  - gate_open port exists and qualifies eligibility in IDLE only.
  - A gate closing during PASS does not truncate the packet.
- TSN_GATE_CTRL_EN undefined:
  - gate_open port is absent and all gates are treated open.
  - Behaviour is pure strict priority.

## Test plan
- Single request: queue 1 sends a 3-beat packet with m_axis_tready=1 → IDLE one cycle, grant_q=1, beats appear in cycles 1–3 unmodified, busy falls after beat 3.
- Contention: queues 0 and 3 valid in the same cycle with 2-beat packets each → queue 3 packet first, 1 idle cycle, then queue 0; grant_q sequence 3,3,x,0,0.
- No preemption: queue 0 mid-packet (4 beats) when queue 3 asserts valid at beat 2 → queue 0 completes all 4 beats before grant_q=3.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 3-beat packet → m_axis_tdata held stable while stalled, no beat lost or duplicated, s_axis_tready[grant_q] mirrors m_axis_tready.
- Gate (TSN_GATE_CTRL_EN): gate_open=4'b0111 with queues 3 and 2 valid → queue 2 granted. Then gate_open=4'b1000 asserted mid-packet → queue 2 finishes, next grant goes to queue 3.
- Reset mid-packet: assert reset at beat 2 of a 4-beat packet → m_axis_tvalid, s_axis_tready, busy and grant_q go to 0 asynchronously; after release, the next packet is arbitrated normally.

Source files
------------

// File: rtl/tsn_strict_priority_scheduler.sv
// tsn_strict_priority_scheduler
// Packet-granular strict-priority egress merge of NUM_QUEUES AXI4-Stream
// traffic-class queues onto one egress stream. The highest queue index wins.
// A grant is held until that queue's tlast handshake, and one idle cycle
// follows every packet so that arbitration can run again.
// Optional feature macro: TSN_GATE_CTRL_EN. When it is defined, a gate_open
// port is added and qualifies which classes may start a packet.
module tsn_strict_priority_scheduler #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES    = 4,
    localparam int QW = $clog2(NUM_QUEUES),
    localparam int KW = C_DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_QUEUES*C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_QUEUES*KW-1:0]              s_axis_tkeep,
    input  logic [NUM_QUEUES*C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                 s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                 s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                 s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [KW-1:0]                         m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
`ifdef TSN_GATE_CTRL_EN
    input  logic [NUM_QUEUES-1:0]                 gate_open,
`endif
    output logic [QW-1:0]                         grant_q,
    output logic                                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [QW-1:0]           grant_d;
    logic                    busy_q;
    logic                    busy_d;
    logic [NUM_QUEUES-1:0]   eligible_s;
    logic [31:0]             grant_idx_s;

    // Index of the highest set bit of v. This function is only used when at
    // least one bit is set.
    function automatic logic [QW-1:0] highest_idx(input logic [NUM_QUEUES-1:0] v);
        logic [QW-1:0] idx;
        idx = {QW{1'b0}};
        for (int q = 0; q < NUM_QUEUES; q++) begin
            idx = v[q] ? QW'(q) : idx;
        end
        return idx;
    endfunction

    assign busy        = busy_q;
    assign grant_idx_s = 32'(grant_q);

    // Determine which classes may start a packet. The gate matters only at packet start.
    always_comb begin
`ifdef TSN_GATE_CTRL_EN
        eligible_s = s_axis_tvalid & gate_open;
`else
        eligible_s = s_axis_tvalid;
`endif
    end

    // Arbitration state, held grant and busy flag; an asynchronous reset aborts any packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= {QW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    // Compute next state and drive the egress/ingress handshake from the held grant.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        busy_d        = busy_q;
        s_axis_tready = {NUM_QUEUES{1'b0}};
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = s_axis_tdata[grant_idx_s*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[grant_idx_s*KW +: KW];
        m_axis_tuser  = s_axis_tuser[grant_idx_s*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        case (state_q)
            ST_IDLE: begin
                if (|eligible_s) begin
                    grant_d = highest_idx(eligible_s);
                    busy_d  = 1'b1;
                    state_d = ST_PASS;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                // The source's valid passes straight through. A source gap becomes a
                // bubble, and the grant stays where it is.
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                m_axis_tlast           = s_axis_tlast[grant_q];
                s_axis_tready[grant_q] = m_axis_tready;
                if (s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q]) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_PASS;
                end
            end
            default: begin
                grant_d = {QW{1'b0}};
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tsn_strict_priority_scheduler.sv
// tb_tsn_strict_priority_scheduler
// Directed-vector bench for the strict-priority scheduler. It uses a
// packet-ownership model together with literal trace expectations for each
// scenario. Define TSN_GATE_CTRL_EN to also exercise gate_open.
module tb_tsn_strict_priority_scheduler;

    localparam int NQ = 4;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NQ*DW-1:0]  s_axis_tdata;
    logic [NQ*KW-1:0]  s_axis_tkeep;
    logic [NQ*UW-1:0]  s_axis_tuser;
    logic [NQ-1:0]     s_axis_tvalid;
    logic [NQ-1:0]     s_axis_tlast;
    logic [NQ-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [NQ-1:0]     gate_open;
    logic [1:0]        grant_q;
    logic              busy;

    tsn_strict_priority_scheduler #(
        .C_DATA_WIDTH (DW),
        .C_TUSER_WIDTH(UW),
        .NUM_QUEUES   (NQ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
`ifdef TSN_GATE_CTRL_EN
        .gate_open    (gate_open),
`endif
        .grant_q      (grant_q),
        .busy         (busy)
    );

    always #4 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] srcq [NQ][$];
    logic [30:0] cur_id [NQ];
    logic        cur_last [NQ];
    logic [NQ-1:0] hold;
    logic [NQ-1:0] hs;
    int          owner = -1;
    int          last_grant = 0;
    int          lg_out[$];
    int          lg_busy[$];
    int          lg_grant[$];
    int          lg_trdy[$];
    int          ex[$];

    function automatic logic [DW-1:0] mk_data(input logic [30:0] id);
        return {8{1'b0, id}};
    endfunction
    function automatic logic [KW-1:0] mk_keep(input logic [30:0] id);
        return {16'hFFFF, id[15:0]};
    endfunction
    function automatic logic [UW-1:0] mk_user(input logic [30:0] id);
        return {4{~{1'b0, id}}};
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present the head beat of every source queue unless that queue is held off.
    task automatic drive();
        for (int q = 0; q < NQ; q++) begin
            if (srcq[q].size() > 0 && !hold[q]) begin
                cur_id[q]   = srcq[q][0][30:0];
                cur_last[q] = srcq[q][0][31];
            end else begin
                cur_id[q]   = 31'd0;
                cur_last[q] = 1'b0;
            end
            s_axis_tvalid[q]            = (srcq[q].size() > 0 && !hold[q]);
            s_axis_tlast[q]             = cur_last[q];
            s_axis_tdata[q*DW +: DW]    = s_axis_tvalid[q] ? mk_data(cur_id[q]) : {DW{1'b0}};
            s_axis_tkeep[q*KW +: KW]    = s_axis_tvalid[q] ? mk_keep(cur_id[q]) : {KW{1'b0}};
            s_axis_tuser[q*UW +: UW]    = s_axis_tvalid[q] ? mk_user(cur_id[q]) : {UW{1'b0}};
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int q = 0; q < NQ; q++) begin
            if (hs[q]) void'(srcq[q].pop_front());
        end
        drive();
    endtask

    task automatic push_pkt(input int q, input int pkt, input int n);
        for (int b = 0; b < n; b++) begin
            srcq[q].push_back({(b == n - 1), 31'(q * 256 + pkt * 16 + b)});
        end
    endtask

    task automatic clr();
        lg_out.delete(); lg_busy.delete(); lg_grant.delete(); lg_trdy.delete();
    endtask

    task automatic check_trace(input string nm, input int sel);
        int got;
        check({nm, " len"}, 256'(lg_out.size()), 256'(ex.size()));
        for (int i = 0; i < ex.size() && i < lg_out.size(); i++) begin
            case (sel)
                0:       got = lg_out[i];
                1:       got = lg_busy[i];
                2:       got = lg_grant[i];
                default: got = lg_trdy[i];
            endcase
            check($sformatf("%s[%0d]", nm, i), 256'(got), 256'(ex[i]));
        end
    endtask

    // Per-cycle compare against the ownership model, followed by the model's advance.
    always @(negedge clk) begin
        logic [NQ-1:0] gate_eff;
        logic [NQ-1:0] exp_trdy;
`ifdef TSN_GATE_CTRL_EN
        gate_eff = gate_open;
`else
        gate_eff = {NQ{1'b1}};
`endif
        if (reset) begin
            check("rst tvalid", 256'(m_axis_tvalid), 256'(0));
            check("rst tready", 256'(s_axis_tready), 256'(0));
            check("rst busy", 256'(busy), 256'(0));
            check("rst grant", 256'(grant_q), 256'(0));
            owner = -1;
            last_grant = 0;
            hs = '0;
        end else begin
            if (owner < 0) begin
                check("idle tvalid", 256'(m_axis_tvalid), 256'(0));
                check("idle tlast", 256'(m_axis_tlast), 256'(0));
                check("idle tready", 256'(s_axis_tready), 256'(0));
                check("idle busy", 256'(busy), 256'(0));
                check("idle grant", 256'(grant_q), 256'(last_grant));
            end else begin
                exp_trdy = m_axis_tready ? (NQ'(1) << owner) : NQ'(0);
                check("pass tvalid", 256'(m_axis_tvalid), 256'(s_axis_tvalid[owner]));
                check("pass tready", 256'(s_axis_tready), 256'(exp_trdy));
                check("pass busy", 256'(busy), 256'(1));
                check("pass grant", 256'(grant_q), 256'(owner));
                if (s_axis_tvalid[owner]) begin
                    check("pass tdata", m_axis_tdata, mk_data(cur_id[owner]));
                    check("pass tkeep", 256'(m_axis_tkeep), 256'(mk_keep(cur_id[owner])));
                    check("pass tuser", 256'(m_axis_tuser), 256'(mk_user(cur_id[owner])));
                    check("pass tlast", 256'(m_axis_tlast), 256'(cur_last[owner]));
                end
            end
            hs = s_axis_tvalid & s_axis_tready;
            if (owner < 0) begin
                for (int q = NQ - 1; q >= 0; q--) begin
                    if (owner < 0 && s_axis_tvalid[q] && gate_eff[q]) owner = q;
                end
                if (owner >= 0) last_grant = owner;
            end else if (s_axis_tvalid[owner] && m_axis_tready && cur_last[owner]) begin
                owner = -1;
            end
        end
        lg_out.push_back((m_axis_tvalid && m_axis_tready) ? int'(m_axis_tdata[30:0]) : -1);
        lg_busy.push_back(int'(busy));
        lg_grant.push_back(int'(grant_q));
        lg_trdy.push_back(int'(s_axis_tready));
    end

    initial begin
        reset = 1'b1;
        m_axis_tready = 1'b0;
        hold = '0;
        hs = '0;
        gate_open = 4'b1111;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tvalid = '0; s_axis_tlast = '0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 256'(busy), 256'(0));
        check("reset grant", 256'(grant_q), 256'(0));
        check("reset m_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("reset m_tlast", 256'(m_axis_tlast), 256'(0));
        check("reset s_tready", 256'(s_axis_tready), 256'(0));
        reset = 1'b0;
        cyc(); cyc();

        // Single request: q1, 3 beats.
        clr(); push_pkt(1, 0, 3); m_axis_tready = 1'b1; drive();
        repeat (5) cyc();
        ex = {-1, 'h100, 'h101, 'h102, -1}; check_trace("s1 out", 0);
        ex = {0, 1, 1, 1, 0};               check_trace("s1 busy", 1);
        ex = {0, 1, 1, 1, 1};               check_trace("s1 grant", 2);

        // Contention: q0 and q3 in the same cycle.
        clr(); push_pkt(0, 1, 2); push_pkt(3, 1, 2); drive();
        repeat (7) cyc();
        ex = {-1, 'h310, 'h311, -1, 'h010, 'h011, -1}; check_trace("s2 out", 0);
        ex = {1, 3, 3, 3, 0, 0, 0};                   check_trace("s2 grant", 2);

        // No preemption: q3 arrives at beat 2 of a 4-beat q0 packet.
        clr(); push_pkt(0, 2, 4); drive();
        repeat (3) cyc();
        push_pkt(3, 2, 2); drive();
        repeat (6) cyc();
        ex = {-1, 'h020, 'h021, 'h022, 'h023, -1, 'h320, 'h321, -1}; check_trace("s3 out", 0);

        // Backpressure: m_axis_tready 1,0,0,1 during a 3-beat q2 packet.
        clr(); push_pkt(2, 3, 3); drive();
        cyc(); m_axis_tready = 1'b1;
        cyc(); m_axis_tready = 1'b0;
        cyc(); m_axis_tready = 1'b0;
        cyc(); m_axis_tready = 1'b1;
        repeat (3) cyc();
        ex = {-1, 'h230, -1, -1, 'h231, 'h232, -1}; check_trace("s4 out", 0);
        ex = {0, 4, 0, 0, 4, 4, 0};                 check_trace("s4 tready", 3);

        // Source bubble mid-packet: grant held, valid drops for one cycle.
        clr(); push_pkt(1, 4, 3); drive();
        cyc();
        cyc(); hold[1] = 1'b1; drive();
        cyc(); hold[1] = 1'b0; drive();
        repeat (3) cyc();
        ex = {-1, 'h140, -1, 'h141, 'h142, -1}; check_trace("s5 out", 0);
        ex = {0, 1, 1, 1, 1, 0};                check_trace("s5 busy", 1);

`ifdef TSN_GATE_CTRL_EN
        // Gate: q3 closed at start; q2 gate closes mid-packet without truncation.
        clr(); gate_open = 4'b0111; push_pkt(3, 5, 2); push_pkt(2, 5, 2); drive();
        cyc(); gate_open = 4'b1000;
        repeat (6) cyc();
        ex = {-1, 'h250, 'h251, -1, 'h350, 'h351, -1}; check_trace("s6 out", 0);
        ex = {1, 2, 2, 2, 3, 3, 3};                   check_trace("s6 grant", 2);
        gate_open = 4'b1111;
`endif

        // Reset at beat 2 of a 4-beat q1 packet, then normal arbitration.
        clr(); push_pkt(1, 6, 4); drive();
        cyc();
        cyc(); reset = 1'b1;
        #1;
        check("async busy", 256'(busy), 256'(0));
        check("async grant", 256'(grant_q), 256'(0));
        check("async m_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("async s_tready", 256'(s_axis_tready), 256'(0));
        cyc(); reset = 1'b0;
        clr(); push_pkt(0, 6, 1); drive();
        repeat (7) cyc();
        ex = {-1, 'h161, 'h162, 'h163, -1, 'h060, -1}; check_trace("s7 out", 0);

        for (int q = 0; q < NQ; q++) begin
            check($sformatf("drain q%0d", q), 256'(srcq[q].size()), 256'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
